// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-side bus between the IF/MEM stages, the arbiter and the unified memory.
// slave = arbiter view, master = pipeline + memory view.
interface mem_port_arbiter_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 2;

  logic          IF_Req;
  logic [AW-1:0] IF_Addr;
  logic          IF_Ack;
  logic [DW-1:0] IF_Data;

  logic          MEM_Req;
  logic          MEM_Write;
  logic [AW-1:0] MEM_Addr;
  logic [DW-1:0] MEM_WData;
  logic [BW-1:0] MEM_ByteSel;
  logic          MEM_Ack;
  logic [DW-1:0] MEM_RData;

  logic          Mem_En;
  logic          Mem_We;
  logic [AW-1:0] Mem_Addr;
  logic [DW-1:0] Mem_WData;
  logic [BW-1:0] Mem_ByteSel;
  logic [DW-1:0] Mem_RData;

  logic          Stall_IF;
  logic          Stall_MEM;

  modport slave (
    input  IF_Req, IF_Addr, MEM_Req, MEM_Write, MEM_Addr, MEM_WData, MEM_ByteSel, Mem_RData,
    output IF_Ack, IF_Data, MEM_Ack, MEM_RData,
    output Mem_En, Mem_We, Mem_Addr, Mem_WData, Mem_ByteSel,
    output Stall_IF, Stall_MEM
  );

  modport master (
    output IF_Req, IF_Addr, MEM_Req, MEM_Write, MEM_Addr, MEM_WData, MEM_ByteSel, Mem_RData,
    input  IF_Ack, IF_Data, MEM_Ack, MEM_RData,
    input  Mem_En, Mem_We, Mem_Addr, Mem_WData, Mem_ByteSel,
    input  Stall_IF, Stall_MEM
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between IF (fetch) and MEM (load/store) with fixed-latency sequencing.
// Define ARB_RR_EN for round-robin on simultaneous requests; default is fixed MEM-over-IF priority.
module mem_port_arbiter #(
  parameter int unsigned LAT = 2,
  parameter int unsigned CW  = 4
) (
  input  logic            Clk,
  input  logic            Rst,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 2;

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, DONE} state_t;

  state_t        r_state,       w_state_nxt;
  logic [CW-1:0] r_cnt,         w_cnt_nxt;
  logic          r_mem_en,      w_mem_en_nxt;
  logic          r_mem_we,      w_mem_we_nxt;
  logic [AW-1:0] r_mem_addr,    w_mem_addr_nxt;
  logic [DW-1:0] r_mem_wdata,   w_mem_wdata_nxt;
  logic [BW-1:0] r_mem_bytesel, w_mem_bytesel_nxt;
  logic [DW-1:0] r_if_data,     w_if_data_nxt;
  logic [DW-1:0] r_mem_rdata,   w_mem_rdata_nxt;
  logic          r_if_ack,      w_if_ack_nxt;
  logic          r_mem_ack,     w_mem_ack_nxt;
  logic          w_pick_mem;

`ifdef ARB_RR_EN
  // Last grant: 0 = IF, 1 = MEM; on a tie the other requester wins.
  logic r_last_mem, w_last_mem_nxt;
  assign w_pick_mem = bus.MEM_Req & (~bus.IF_Req | ~r_last_mem);
`else
  assign w_pick_mem = bus.MEM_Req;
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_mem_en      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_bytesel <= '0;
      r_if_data     <= '0;
      r_mem_rdata   <= '0;
      r_if_ack      <= 1'b0;
      r_mem_ack     <= 1'b0;
`ifdef ARB_RR_EN
      r_last_mem    <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_mem_en      <= w_mem_en_nxt;
      r_mem_we      <= w_mem_we_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_mem_wdata   <= w_mem_wdata_nxt;
      r_mem_bytesel <= w_mem_bytesel_nxt;
      r_if_data     <= w_if_data_nxt;
      r_mem_rdata   <= w_mem_rdata_nxt;
      r_if_ack      <= w_if_ack_nxt;
      r_mem_ack     <= w_mem_ack_nxt;
`ifdef ARB_RR_EN
      r_last_mem    <= w_last_mem_nxt;
`endif
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_mem_en_nxt      = r_mem_en;
    w_mem_we_nxt      = r_mem_we;
    w_mem_addr_nxt    = r_mem_addr;
    w_mem_wdata_nxt   = r_mem_wdata;
    w_mem_bytesel_nxt = r_mem_bytesel;
    w_if_data_nxt     = r_if_data;
    w_mem_rdata_nxt   = r_mem_rdata;
    w_if_ack_nxt      = 1'b0;
    w_mem_ack_nxt     = 1'b0;
`ifdef ARB_RR_EN
    w_last_mem_nxt    = r_last_mem;
`endif
    case (r_state)
      IDLE: begin
        if (bus.MEM_Req || bus.IF_Req) begin
          w_state_nxt       = w_pick_mem ? BUSY_MEM : BUSY_IF;
          w_cnt_nxt         = CW'(LAT);
          w_mem_en_nxt      = 1'b1;
          w_mem_we_nxt      = w_pick_mem & bus.MEM_Write;
          w_mem_addr_nxt    = w_pick_mem ? bus.MEM_Addr : bus.IF_Addr;
          w_mem_wdata_nxt   = w_pick_mem ? bus.MEM_WData : '0;
          w_mem_bytesel_nxt = w_pick_mem ? bus.MEM_ByteSel : '0;
`ifdef ARB_RR_EN
          w_last_mem_nxt    = w_pick_mem;
`endif
        end
      end
      BUSY_IF, BUSY_MEM: begin
        if (r_cnt == CW'(1)) begin
          w_state_nxt  = DONE;
          w_cnt_nxt    = '0;
          w_mem_en_nxt = 1'b0;
          w_mem_we_nxt = 1'b0;
          if (r_state == BUSY_IF) begin
            w_if_data_nxt = bus.Mem_RData;
            w_if_ack_nxt  = 1'b1;
          end else begin
            if (!r_mem_we) w_mem_rdata_nxt = bus.Mem_RData;
            w_mem_ack_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      // Pipeline advances on this edge, so no request is sampled here.
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.IF_Ack      = r_if_ack;
  assign bus.IF_Data     = r_if_data;
  assign bus.MEM_Ack     = r_mem_ack;
  assign bus.MEM_RData   = r_mem_rdata;
  assign bus.Mem_En      = r_mem_en;
  assign bus.Mem_We      = r_mem_we;
  assign bus.Mem_Addr    = r_mem_addr;
  assign bus.Mem_WData   = r_mem_wdata;
  assign bus.Mem_ByteSel = r_mem_bytesel;
  assign bus.Stall_IF    = bus.IF_Req & ~r_if_ack;
  assign bus.Stall_MEM   = bus.MEM_Req & ~r_mem_ack;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: lane 0 runs LAT=2, lane 1 runs LAT=1, each against a timeline model.
module tb_mem_port_arbiter;
  localparam int NL = 2;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  logic        if_req   [NL];
  logic [31:0] if_addr  [NL];
  logic        mem_req  [NL];
  logic        mem_write[NL];
  logic [31:0] mem_addr [NL];
  logic [31:0] mem_wdata[NL];
  logic [1:0]  mem_bs   [NL];
  bit          if_step  [NL];

  logic        o_if_ack[NL], o_mem_ack[NL], o_en[NL], o_we[NL], o_stall_if[NL], o_stall_mem[NL];
  logic [31:0] o_if_data[NL], o_mem_rdata[NL], o_addr[NL], o_wdata[NL];
  logic [1:0]  o_bs[NL];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a == 32'h40) ? 32'h2008000A : {a[15:0], ~a[15:0]};
  endfunction

  function automatic int lat_of(input int l);
    return (l == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string nm, input int ln, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s lane%0d t=%0t: got %h expected %h", nm, ln, $time, act, exp);
    end
  endtask

  for (genvar l = 0; l < NL; l++) begin : g_lane
    localparam int unsigned LLAT = (l == 0) ? 2 : 1;
    mem_port_arbiter_if bus();
    int age;

    assign bus.IF_Req      = if_req[l];
    assign bus.IF_Addr     = if_addr[l];
    assign bus.MEM_Req     = mem_req[l];
    assign bus.MEM_Write   = mem_write[l];
    assign bus.MEM_Addr    = mem_addr[l];
    assign bus.MEM_WData   = mem_wdata[l];
    assign bus.MEM_ByteSel = mem_bs[l];
    // Memory returns the real word only in the last cycle of a LAT-cycle enable window.
    assign bus.Mem_RData   = (bus.Mem_En && age == int'(LLAT) - 1) ? memfn(bus.Mem_Addr)
                                                                    : (32'hBAD0_0000 ^ bus.Mem_Addr);
    always @(posedge Clk or negedge Rst)
      if (!Rst) age <= 0;
      else      age <= bus.Mem_En ? age + 1 : 0;

    assign o_if_ack[l]    = bus.IF_Ack;
    assign o_mem_ack[l]   = bus.MEM_Ack;
    assign o_en[l]        = bus.Mem_En;
    assign o_we[l]        = bus.Mem_We;
    assign o_stall_if[l]  = bus.Stall_IF;
    assign o_stall_mem[l] = bus.Stall_MEM;
    assign o_if_data[l]   = bus.IF_Data;
    assign o_mem_rdata[l] = bus.MEM_RData;
    assign o_addr[l]      = bus.Mem_Addr;
    assign o_wdata[l]     = bus.Mem_WData;
    assign o_bs[l]        = bus.Mem_ByteSel;

    mem_port_arbiter #(.LAT(LLAT), .CW(4)) u_dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
    );
  end

  // Timeline model: an access granted at edge g owns cycles g..g+LAT, ack in g+LAT, idle again at g+LAT+1.
  bit          act[NL], who_mem[NL], wr[NL], last_mem[NL];
  int          g[NL], cyc[NL];
  logic [31:0] a[NL], wd[NL], e_if[NL], e_mem[NL];
  logic [1:0]  bs[NL];

  always @(posedge Clk or negedge Rst) begin
    for (int l = 0; l < NL; l++) begin
      int c;
      bit pm;
      if (!Rst) begin
        act[l] <= 1'b0; cyc[l] <= 0; g[l] <= 0; last_mem[l] <= 1'b0;
        e_if[l] <= '0; e_mem[l] <= '0;
      end else begin
        c = cyc[l] + 1;
        cyc[l] <= c;
        if (act[l] && c == g[l] + lat_of(l)) begin
          if (!who_mem[l])  e_if[l]  <= memfn(a[l]);
          else if (!wr[l])  e_mem[l] <= memfn(a[l]);
        end
        if (act[l] && c == g[l] + lat_of(l) + 1) begin
          act[l] <= 1'b0;
        end else if (!act[l] && (mem_req[l] || if_req[l])) begin
`ifdef ARB_RR_EN
          pm = mem_req[l] && (!if_req[l] || !last_mem[l]);
`else
          pm = mem_req[l];
`endif
          last_mem[l] <= pm;
          act[l]      <= 1'b1;
          g[l]        <= c;
          who_mem[l]  <= pm;
          wr[l]       <= pm && mem_write[l];
          a[l]        <= pm ? mem_addr[l] : if_addr[l];
          wd[l]       <= mem_wdata[l];
          bs[l]       <= mem_bs[l];
        end
      end
    end
  end

  always @(negedge Clk) begin
    for (int l = 0; l < NL; l++) begin
      bit een, eia, ema;
      een = Rst && act[l] && cyc[l] < g[l] + lat_of(l);
      eia = Rst && act[l] && !who_mem[l] && cyc[l] == g[l] + lat_of(l);
      ema = Rst && act[l] &&  who_mem[l] && cyc[l] == g[l] + lat_of(l);
      chk("Mem_En",    l, 32'(o_en[l]),        32'(een));
      chk("Mem_We",    l, 32'(o_we[l]),        32'(een && wr[l]));
      chk("IF_Ack",    l, 32'(o_if_ack[l]),    32'(eia));
      chk("MEM_Ack",   l, 32'(o_mem_ack[l]),   32'(ema));
      chk("AckExcl",   l, 32'(o_if_ack[l] & o_mem_ack[l]), 32'd0);
      chk("IF_Data",   l, o_if_data[l],        e_if[l]);
      chk("MEM_RData", l, o_mem_rdata[l],      e_mem[l]);
      chk("Stall_IF",  l, 32'(o_stall_if[l]),  32'(if_req[l] & ~eia));
      chk("Stall_MEM", l, 32'(o_stall_mem[l]), 32'(mem_req[l] & ~ema));
      if (een) chk("Mem_Addr", l, o_addr[l], a[l]);
      if (een && who_mem[l]) begin
        chk("Mem_WData",   l, o_wdata[l],   wd[l]);
        chk("Mem_ByteSel", l, 32'(o_bs[l]), 32'(bs[l]));
      end
      if (!Rst) chk("Mem_Addr_rst", l, o_addr[l], 32'd0);
    end
  end

  // Runs ncyc cycles from the next edge; drops (or steps) a request after its ack.
  task automatic run(input int l, input int ncyc, output int if_at, output int mem_at, output int n_if);
    if_at = 0; mem_at = 0; n_if = 0;
    @(posedge Clk);
    for (int c = 1; c <= ncyc; c++) begin
      bit si, sm;
      @(negedge Clk);
      si = o_if_ack[l];
      sm = o_mem_ack[l];
      if (si) begin n_if++; if (if_at == 0) if_at = c; end
      if (sm && mem_at == 0) mem_at = c;
      @(posedge Clk); #2;
      if (si) begin
        if (if_step[l]) if_addr[l] = if_addr[l] + 32'd4;
        else            if_req[l]  = 1'b0;
      end
      if (sm) mem_req[l] = 1'b0;
    end
  endtask

  initial begin
    int ia, ma, ni;
    for (int l = 0; l < NL; l++) begin
      if_req[l] = 1'b0; if_addr[l] = '0; mem_req[l] = 1'b0; mem_write[l] = 1'b0;
      mem_addr[l] = '0; mem_wdata[l] = '0; mem_bs[l] = '0; if_step[l] = 1'b0;
    end
    repeat (3) @(posedge Clk);
    #2 Rst = 1'b1;

    // Instruction fetch, LAT=2
    if_addr[0] = 32'h40; if_req[0] = 1'b1;
    run(0, 6, ia, ma, ni);
    chk("lit_fetch_ack_cycle", 0, 32'(ia), 32'd3);
    chk("lit_fetch_data",      0, o_if_data[0], 32'h2008000A);
    chk("lit_fetch_no_memack", 0, 32'(ma), 32'd0);

    // Store
    mem_addr[0] = 32'h100; mem_wdata[0] = 32'hDEADBEEF; mem_bs[0] = 2'b00;
    mem_write[0] = 1'b1; mem_req[0] = 1'b1;
    run(0, 6, ia, ma, ni);
    chk("lit_store_ack_cycle", 0, 32'(ma), 32'd3);
    chk("lit_store_rdata",     0, o_mem_rdata[0], 32'd0);

    // Simultaneous requests; last grant was MEM
    if_addr[0] = 32'h44; if_req[0] = 1'b1;
    mem_addr[0] = 32'h200; mem_write[0] = 1'b0; mem_req[0] = 1'b1;
    run(0, 12, ia, ma, ni);
`ifdef ARB_RR_EN
    chk("lit_both_if_cycle",  0, 32'(ia), 32'd3);
    chk("lit_both_mem_cycle", 0, 32'(ma), 32'd7);
`else
    chk("lit_both_mem_cycle", 0, 32'(ma), 32'd3);
    chk("lit_both_if_cycle",  0, 32'(ia), 32'd7);
`endif
    chk("lit_both_rdata",  0, o_mem_rdata[0], 32'h0200FDFF);
    chk("lit_both_ifdata", 0, o_if_data[0],   32'h0044FFBB);

    // Reset in the second busy cycle of a load
    mem_addr[0] = 32'h300; mem_write[0] = 1'b0; mem_req[0] = 1'b1;
    @(posedge Clk);
    @(posedge Clk); #2;
    Rst = 1'b0;
    #1;
    chk("lit_rst_en",     0, 32'(o_en[0]),      32'd0);
    chk("lit_rst_ack",    0, 32'(o_mem_ack[0]), 32'd0);
    chk("lit_rst_rdata",  0, o_mem_rdata[0],    32'd0);
    chk("lit_rst_ifdata", 0, o_if_data[0],      32'd0);
    chk("lit_rst_addr",   0, o_addr[0],         32'd0);
    repeat (2) @(posedge Clk);
    #2 Rst = 1'b1;
    run(0, 8, ia, ma, ni);
    chk("lit_regrant_cycle", 0, 32'(ma), 32'd3);
    chk("lit_regrant_rdata", 0, o_mem_rdata[0], 32'h0300FCFF);

    // LAT=1 streaming fetch, one every 3 cycles
    if_step[1] = 1'b1; if_addr[1] = 32'h1000; if_req[1] = 1'b1;
    run(1, 15, ia, ma, ni);
    chk("lit_stream_first", 1, 32'(ia), 32'd2);
    chk("lit_stream_count", 1, 32'(ni), 32'd5);
    chk("lit_stream_data",  1, o_if_data[1], 32'h1010EFEF);
    // Request withdrawn right after the grant edge: access still completes
    if_req[1] = 1'b0; if_step[1] = 1'b0;
    run(1, 6, ia, ma, ni);
    chk("lit_drop_ack_cycle", 1, 32'(ia), 32'd1);
    chk("lit_drop_data",      1, o_if_data[1], 32'h1014EFEB);

    repeat (2) @(posedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
